// File: rtl/bbcd_ctrl_if.sv
// Handshake and datapath bundle between the host, the LSR_BBCD shift register and bbcd_ctrl.
// The slave modport is the controller's view; master is the host/datapath side.
interface bbcd_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             START;
    logic [WIDTH-1:0] OP_IN;
    logic             BUSY;
    logic             DONE_P;
    logic             OVF;
    logic             LD;
    logic             SH;
    logic [WIDTH-1:0] OP_A;
    logic [3:0]       UNIT_I;
    logic [3:0]       DEC_I;
    logic [3:0]       CENT_I;
    logic [3:0]       MIL_I;
    logic [3:0]       BCD_UNIT;
    logic [3:0]       BCD_DEC;
    logic [3:0]       BCD_CENT;
    logic [3:0]       BCD_MIL;

    modport slave (
        input  START, OP_IN, UNIT_I, DEC_I, CENT_I, MIL_I,
        output BUSY, DONE_P, OVF, LD, SH, OP_A,
               BCD_UNIT, BCD_DEC, BCD_CENT, BCD_MIL
    );

    modport master (
        output START, OP_IN, UNIT_I, DEC_I, CENT_I, MIL_I,
        input  BUSY, DONE_P, OVF, LD, SH, OP_A,
               BCD_UNIT, BCD_DEC, BCD_CENT, BCD_MIL
    );
endinterface

// File: rtl/bbcd_ctrl.sv
// Sequencer for the double-dabble binary-to-BCD shift register: load, then
// alternate add-3 correction and shift WIDTH times, then capture the four digits.
module bbcd_ctrl #(
    parameter int WIDTH   = 16,
    parameter int CNT_W   = 5,
    parameter int MAX_BCD = 9999
) (
    input  logic        CLK,
    input  logic        RST,
    bbcd_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ADD,
        S_SHIFT,
        S_CAPT
    } state_t;

    localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX_BCD);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic             ovf_stage_q, ovf_stage_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;
    logic [15:0]      bcd_q, bcd_d;
    logic             ld, sh, busy;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            op_a_q      <= '0;
            ovf_stage_q <= 1'b0;
            ovf_q       <= 1'b0;
            done_q      <= 1'b0;
            bcd_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_a_q      <= op_a_d;
            ovf_stage_q <= ovf_stage_d;
            ovf_q       <= ovf_d;
            done_q      <= done_d;
            bcd_q       <= bcd_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_a_d      = op_a_q;
        ovf_stage_d = ovf_stage_q;
        ovf_d       = ovf_q;
        done_d      = 1'b0;
        bcd_d       = bcd_q;
        ld          = 1'b0;
        sh          = 1'b0;
        busy        = (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (bus.START) begin
                    op_a_d      = bus.OP_IN;
                    ovf_stage_d = (bus.OP_IN > MAX_V);
                    cnt_d       = '0;
                    state_d     = S_LOAD;
                end
            end
            S_LOAD: begin
                ld      = 1'b1;
                state_d = S_ADD;
            end
            // With both strobes low the shift register applies its add-3 correction.
            S_ADD: begin
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                sh      = 1'b1;
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = (cnt_q == LAST_CNT) ? S_CAPT : S_ADD;
            end
            S_CAPT: begin
                bcd_d   = {bus.MIL_I, bus.CENT_I, bus.DEC_I, bus.UNIT_I};
                ovf_d   = ovf_stage_q;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.LD       = ld;
    assign bus.SH       = sh;
    assign bus.BUSY     = busy;
    assign bus.DONE_P   = done_q;
    assign bus.OVF      = ovf_q;
    assign bus.OP_A     = op_a_q;
    assign bus.BCD_UNIT = bcd_q[3:0];
    assign bus.BCD_DEC  = bcd_q[7:4];
    assign bus.BCD_CENT = bcd_q[11:8];
    assign bus.BCD_MIL  = bcd_q[15:12];
endmodule

// File: tb/tb_bbcd_ctrl.sv
// Bench for bbcd_ctrl: a behavioural LSR_BBCD datapath, a cycle-count reference model
// and directed plus randomized conversions.
module tb_bbcd_ctrl;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   cmp_en = 1'b0;

    always #5 CLK = ~CLK;

    bbcd_ctrl_if #(.WIDTH(16)) bus ();

    bbcd_ctrl #(.WIDTH(16), .CNT_W(5), .MAX_BCD(9999)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    // Behavioural LSR_BBCD: LD loads, SH shifts {A,Op}, otherwise add-3 on nibbles >= 5.
    logic [15:0] dp_a, dp_op;

    function automatic logic [15:0] add3(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = (v[i*4 +: 4] >= 4'd5) ? v[i*4 +: 4] + 4'd3 : v[i*4 +: 4];
        end
        return r;
    endfunction

    always @(posedge CLK) begin
        if (bus.LD) begin
            dp_a  <= '0;
            dp_op <= bus.OP_A;
        end else if (bus.SH) begin
            {dp_a, dp_op} <= {dp_a[14:0], dp_op, 1'b0};
        end else begin
            dp_a <= add3(dp_a);
        end
    end

    assign bus.UNIT_I = dp_a[3:0];
    assign bus.DEC_I  = dp_a[7:4];
    assign bus.CENT_I = dp_a[11:8];
    assign bus.MIL_I  = dp_a[15:12];

    // Reference model: k = cycles since acceptance (0 = idle); result is plain decimal arithmetic.
    int          m_k;
    logic [15:0] m_op;
    bit          m_done;
    int          m_val;
    bit          m_ovf;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_k    <= 0;
            m_op   <= '0;
            m_done <= 1'b0;
            m_val  <= 0;
            m_ovf  <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_k == 0) begin
                if (bus.START) begin
                    m_k  <= 1;
                    m_op <= bus.OP_IN;
                end
            end else if (m_k == 34) begin
                m_k    <= 0;
                m_done <= 1'b1;
                m_val  <= int'(m_op) % 10000;
                m_ovf  <= (int'(m_op) > 9999);
            end else begin
                m_k <= m_k + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (cmp_en) begin
            check("busy",   32'(bus.BUSY),   32'(m_k >= 1 && m_k <= 34));
            check("ld",     32'(bus.LD),     32'(m_k == 1));
            check("sh",     32'(bus.SH),     32'(m_k >= 3 && m_k <= 33 && (m_k % 2) == 1));
            check("done_p", 32'(bus.DONE_P), 32'(m_done));
            check("ovf",    32'(bus.OVF),    32'(m_ovf));
            check("op_a",   32'(bus.OP_A),   32'(m_op));
            check("unit",   32'(bus.BCD_UNIT), 32'(m_val % 10));
            check("dec",    32'(bus.BCD_DEC),  32'((m_val / 10) % 10));
            check("cent",   32'(bus.BCD_CENT), 32'((m_val / 100) % 10));
            check("mil",    32'(bus.BCD_MIL),  32'((m_val / 1000) % 10));
        end
    end

    task automatic start_op(input logic [15:0] op);
        @(negedge CLK);
        bus.START = 1'b1;
        bus.OP_IN = op;
        @(negedge CLK);
        bus.START = 1'b0;
        bus.OP_IN = 16'($urandom);
    endtask

    // Called at the negedge of cycle 1; returns at the DONE_P negedge (or on timeout).
    task automatic wait_done(input bit inject, output int cyc, output int shc,
                             output int busyc, output bit ld1);
        cyc   = 1;
        shc   = 0;
        busyc = 0;
        ld1   = bus.LD;
        while (!bus.DONE_P && cyc < 100) begin
            if (bus.SH)   shc++;
            if (bus.BUSY) busyc++;
            if (inject) begin
                if (cyc == 5 || cyc == 20) begin
                    bus.START = 1'b1;
                    bus.OP_IN = 16'd42;
                end else begin
                    bus.START = 1'b0;
                end
            end
            @(negedge CLK);
            cyc++;
        end
    endtask

    task automatic check_digits(input string name, input int m, input int c, input int d,
                                input int u, input bit o);
        check({name, "_mil"},  32'(bus.BCD_MIL),  32'(m));
        check({name, "_cent"}, 32'(bus.BCD_CENT), 32'(c));
        check({name, "_dec"},  32'(bus.BCD_DEC),  32'(d));
        check({name, "_unit"}, 32'(bus.BCD_UNIT), 32'(u));
        check({name, "_ovf"},  32'(bus.OVF),      32'(o));
    endtask

    task automatic convert(input string name, input logic [15:0] op, input int m, input int c,
                           input int d, input int u, input bit o);
        int cyc, shc, busyc;
        bit ld1;
        start_op(op);
        wait_done(1'b0, cyc, shc, busyc, ld1);
        check({name, "_latency"}, 32'(cyc), 32'd35);
        check({name, "_sh_count"}, 32'(shc), 32'd16);
        check_digits(name, m, c, d, u, o);
        $display("conv %s op=%0d -> %0d%0d%0d%0d ovf=%0d in %0d cycles", name, op,
                 bus.BCD_MIL, bus.BCD_CENT, bus.BCD_DEC, bus.BCD_UNIT, bus.OVF, cyc);
    endtask

    initial begin
        int  cyc, shc, busyc, extra;
        bit  ld1;
        int  v;
        bus.START = 1'b0;
        bus.OP_IN = '0;
        repeat (3) @(posedge CLK);
        #3 RST = 1'b0;
        @(negedge CLK);
        cmp_en = 1'b1;
        check("rst_busy", 32'(bus.BUSY), 32'd0);
        check("rst_ld_sh", 32'({bus.LD, bus.SH}), 32'd0);
        check("rst_op_a", 32'(bus.OP_A), 32'd0);
        check_digits("rst", 0, 0, 0, 0, 1'b0);

        // Zero operand with full timing profile.
        start_op(16'd0);
        wait_done(1'b0, cyc, shc, busyc, ld1);
        check("zero_latency", 32'(cyc), 32'd35);
        check("zero_sh_count", 32'(shc), 32'd16);
        check("zero_busy_cycles", 32'(busyc), 32'd34);
        check("zero_ld_cycle1", 32'(ld1), 32'd1);
        check_digits("zero", 0, 0, 0, 0, 1'b0);
        $display("conv zero op=0 latency=%0d sh=%0d busy=%0d", cyc, shc, busyc);

        convert("c1234", 16'd1234, 1, 2, 3, 4, 1'b0);
        convert("c9999", 16'd9999, 9, 9, 9, 9, 1'b0);
        convert("c65535", 16'd65535, 5, 5, 3, 5, 1'b1);

        // START pulses during a conversion are ignored.
        start_op(16'd700);
        wait_done(1'b1, cyc, shc, busyc, ld1);
        bus.START = 1'b0;
        check("ign_latency", 32'(cyc), 32'd35);
        check_digits("ign", 0, 7, 0, 0, 1'b0);
        extra = 0;
        repeat (40) begin
            @(negedge CLK);
            if (bus.DONE_P) extra++;
        end
        check("ign_extra_done", 32'(extra), 32'd0);
        $display("conv ignore op=700 latency=%0d extra_done=%0d", cyc, extra);

        // Asynchronous reset in the middle of a conversion.
        start_op(16'd500);
        while (cyc != 12) begin
            cyc = (cyc >= 1 && cyc < 12) ? cyc + 1 : 1;
            if (cyc != 12) @(negedge CLK);
        end
        #2 RST = 1'b1;
        #1;
        check("arst_ld_sh", 32'({bus.LD, bus.SH}), 32'd0);
        check("arst_busy", 32'(bus.BUSY), 32'd0);
        check("arst_done", 32'(bus.DONE_P), 32'd0);
        check_digits("arst", 0, 0, 0, 0, 1'b0);
        $display("reset mid-conversion: busy=%0d ld=%0d sh=%0d", bus.BUSY, bus.LD, bus.SH);
        @(negedge CLK);
        #3 RST = 1'b0;
        convert("c77", 16'd77, 0, 0, 7, 7, 1'b0);

        // Back-to-back: START accepted in the DONE_P cycle.
        convert("b2b_a", 16'd1234, 1, 2, 3, 4, 1'b0);
        bus.START = 1'b1;
        bus.OP_IN = 16'd5678;
        @(negedge CLK);
        bus.START = 1'b0;
        check("b2b_busy_now", 32'(bus.BUSY), 32'd1);
        check_digits("b2b_hold", 1, 2, 3, 4, 1'b0);
        wait_done(1'b0, cyc, shc, busyc, ld1);
        check("b2b_latency", 32'(cyc), 32'd35);
        check_digits("b2b_b", 5, 6, 7, 8, 1'b0);
        $display("conv b2b op=5678 -> %0d%0d%0d%0d in %0d cycles", bus.BCD_MIL,
                 bus.BCD_CENT, bus.BCD_DEC, bus.BCD_UNIT, cyc);

        // Randomized operands, weighted toward the four-digit boundary.
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0:       v = int'($urandom_range(0, 9999));
                1:       v = int'($urandom_range(9990, 10010));
                default: v = int'($urandom_range(0, 65535));
            endcase
            convert("rand", 16'(v), (v % 10000) / 1000, (v % 1000) / 100, (v % 100) / 10,
                    v % 10, v > 9999);
        end

        repeat (3) @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
